apb_slave_interface: RTL
========================

APB_SLAVE_INTERFACE -- requirements
Module: apb_slave_interface

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hDEADCA00, base of the decoded region (bits [7:0] ignored).
REQ-002 SHALL have parameter DEPTH, default 64, number of 32-bit registers (power of two, max 64).
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted per transfer (0..15).
REQ-004 SHALL have one clock and an asynchronous active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 psel_i  input  1  slave select.
REQ-008 penable_i  input  1  access phase.
REQ-009 paddr_i  input  32  byte address.
REQ-010 pwrite_i  input  1  1 = write, 0 = read.
REQ-011 pwdata_i  input  32  write data.
REQ-012 pready_o  output  1  transfer completes this cycle.
REQ-013 prdata_o  output  32  read data, valid only while pready_o=1 on a read, else 0.
REQ-014 pslverr_o  output  1  error response, valid only while pready_o=1.

Function
REQ-015 SHALL implement FSM IDLE, ACCESS; IDLE->ACCESS on psel_i=1 and penable_i=0 (setup); ACCESS->IDLE on pready_o=1 or psel_i=0.
REQ-016 On the setup-to-ACCESS edge SHALL latch paddr_i, pwrite_i and pwdata_i, and SHALL load the wait counter with WAIT_CYCLES.
REQ-017 In ACCESS with counter nonzero SHALL decrement the counter each cycle with pready_o=0.
REQ-018 SHALL assert pready_o combinationally when state=ACCESS, counter=0 and psel_i=penable_i=1; latency from setup cycle to pready_o = WAIT_CYCLES+1 cycles.
REQ-019 Address hit SHALL be paddr[31:8]==BASE_ADDR[31:8] and paddr[7:2]<DEPTH; register index = paddr[7:2]; paddr[1:0] ignored.
REQ-020 A write SHALL commit latched pwdata to the indexed register at the rising edge where pready_o=1; no other edge modifies storage.
REQ-021 A read SHALL drive prdata_o with the indexed register contents while pready_o=1.
REQ-022 A miss write SHALL leave all registers unchanged; a miss read SHALL return 0.
REQ-023 penable_i=1 while IDLE (no prior setup) SHALL be ignored: pready_o=0, no state change.
REQ-024 psel_i deasserted during ACCESS SHALL abort: return to IDLE, no write, pready_o=0.
REQ-025 Back-to-back transfers (new setup in the cycle after pready_o) SHALL be accepted with no idle gap.
REQ-026 Changes on paddr_i/pwdata_i/pwrite_i during ACCESS SHALL have no effect (latched values used).

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, counter 0, all registers 0, pready_o=0, prdata_o=0, pslverr_o=0.
REQ-028 Reset mid-transfer SHALL discard the transfer with no register write; first transfer accepted is the first setup after reset release.

Configuration
REQ-029 Macro APB_SLVERR_EN defined: pslverr_o SHALL be 1 with pready_o on any miss, 0 on hit.
REQ-030 Macro APB_SLVERR_EN undefined: pslverr_o SHALL be constant 0; miss behaviour otherwise per REQ-022.

Verification
REQ-031 Write 32'h00000002 to 32'hDEADCAFE (WAIT_CYCLES=1), then read same address -> pready_o high 2 cycles after each setup; read returns 32'h00000002; pslverr_o=0.
REQ-032 Write 32'h12345678 to 32'hDEADCA04 then read 32'hDEADCA05 -> read returns 32'h12345678 (low bits ignored).
REQ-033 Write to 32'h00000000, then read it (APB_SLVERR_EN defined) -> pslverr_o=1 with pready_o, prdata_o=0, no register changed; undefined -> pslverr_o=0.
REQ-034 Write 32'hA5A5A5A5 to 32'hDEADCA10, drop psel_i in ACCESS before pready_o, then read -> returns 0, FSM back to IDLE.
REQ-035 Assert reset=0 during ACCESS of a write to 32'hDEADCA08 -> all outputs 0 immediately; after release, read returns 0.
REQ-036 WAIT_CYCLES=0: two back-to-back writes to 32'hDEADCA00 and 32'hDEADCA3C -> pready_o in each first ACCESS cycle; both values read back correctly.

Source files
------------

// File: rtl/apb_slave_interface.sv
// ============================================================================
// apb_slave_interface
// ----------------------------------------------------------------------------
// Purpose : APB slave that decodes a 256-byte region at BASE_ADDR and exposes
//           DEPTH 32-bit registers. Each transfer inserts WAIT_CYCLES wait
//           states. Address, direction and write data are latched in the
//           setup cycle and used unchanged for the rest of the transfer.
//
// Parameters
//   BASE_ADDR   : base of the decoded region (bits [7:0] ignored)
//   DEPTH       : number of 32-bit registers (power of two, 1..64)
//   WAIT_CYCLES : wait states per transfer (0..15)
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous active-low reset
//   psel_i     in   1   slave select
//   penable_i  in   1   access phase
//   paddr_i    in  32   byte address
//   pwrite_i   in   1   1 = write, 0 = read
//   pwdata_i   in  32   write data
//   pready_o   out  1   transfer completes this cycle
//   prdata_o   out 32   read data (0 unless completing a read hit)
//   pslverr_o  out  1   error response (meaningful only with pready_o)
//
// Configuration
//   APB_SLVERR_EN : when defined, pslverr_o flags an out-of-range access at
//                   completion; when undefined, pslverr_o is tied to 0.
// ============================================================================
module apb_slave_interface #(
    parameter logic [31:0] BASE_ADDR   = 32'hDEADCA00,
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic               w_latch;

    // Only word address bits are kept; byte lane bits play no part in decode.
    logic [31:2]        r_addr;
    logic               r_write;
    logic [31:0]        r_wdata;

    logic [31:0]        r_mem [DEPTH];

    logic               w_in_range;
    logic               w_hit;
    logic [IDX_W-1:0]   w_idx;
    logic               w_commit;
    logic               w_unused;

    assign w_unused = ^paddr_i[1:0];

    // ------------------------------------------------------------------
    // Address decode on the latched address
    // ------------------------------------------------------------------
    generate
        if (DEPTH >= 64) begin : g_full
            assign w_in_range = 1'b1;
        end else begin : g_part
            assign w_in_range = (r_addr[7:2] < 6'(DEPTH));
        end
    endgenerate

    assign w_hit = (r_addr[31:8] == BASE_ADDR[31:8]) && w_in_range;
    assign w_idx = r_addr[2 +: IDX_W];

    // ------------------------------------------------------------------
    // Handshake outputs
    // ------------------------------------------------------------------
    // pready_o also requires psel_i/penable_i so that a master dropping
    // psel_i mid-transfer never sees a completion (abort path).
    assign pready_o = (r_state == S_ACCESS) && (r_cnt == 4'd0) && psel_i && penable_i;
    assign prdata_o = (pready_o && !r_write && w_hit) ? r_mem[w_idx] : 32'd0;

`ifdef APB_SLVERR_EN
    assign pslverr_o = pready_o && !w_hit;
`else
    assign pslverr_o = 1'b0;
`endif

    assign w_commit = pready_o && r_write && w_hit;

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned; that is what keeps this block free of latches.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // penable_i without a preceding setup is ignored here.
                if (psel_i && !penable_i) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = 4'(WAIT_CYCLES);
                    w_latch     = 1'b1;
                end
            end
            S_ACCESS: begin
                if (!psel_i || pready_o) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state, wait counter and transfer latches
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_addr  <= paddr_i[31:2];
                r_write <= pwrite_i;
                r_wdata <= pwdata_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    // NOTE: the register file is cleared by reset because software expects
    // every register to read 0 after reset; this forces a flop-based array
    // rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_commit) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

endmodule
